ram_large_arbiter: RTL

//  Two-port arbiter/sequencer in front of the 4-bank single-port sync RAM (16-bit, 14-bit addr).

---
 rtl/mem_ctrl_pkg.sv | 33 +++
 rtl/mem_rr_arb2.sv | 46 ++++
 rtl/ram_large_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the RAM arbiter/sequencer: FSM state encoding, port identifiers
// and the round-robin pick helper used by the arbiter.
package mem_ctrl_pkg;

    localparam int MEM_ADDR_WIDTH = 14;
    localparam int MEM_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDATA  = 2'd2
    } memctl_state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LS = 1'b1
    } mem_port_t;

    // On a tie the port that did not win last time is chosen.
    function automatic mem_port_t rr_pick(input logic if_req, input logic ls_req,
                                          input mem_port_t last_grant);
        mem_port_t pick;
        if (if_req && ls_req) begin
            pick = (last_grant == PORT_IF) ? PORT_LS : PORT_IF;
        end else if (ls_req) begin
            pick = PORT_LS;
        end else begin
            pick = PORT_IF;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_rr_arb2.sv
// Two-way round-robin arbiter between instruction fetch and load/store.
// The grant is combinational; last_grant advances on every issued grant.
module mem_rr_arb2
    import mem_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      en,
    input  logic      if_req,
    input  logic      ls_req,
    output logic      gnt_valid,
    output mem_port_t gnt_port
);

    mem_port_t last_grant_r;
    logic      gnt_valid_s;
    mem_port_t gnt_port_s;

    // Grant decision for the current cycle.
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_port_s  = PORT_IF;
        if (en && (if_req || ls_req)) begin
            gnt_valid_s = 1'b1;
            gnt_port_s  = rr_pick(if_req, ls_req, last_grant_r);
        end else begin
            gnt_valid_s = 1'b0;
            gnt_port_s  = PORT_IF;
        end
    end

    // Remember the winner; reset to IF so the first tie goes to LS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= PORT_IF;
        end else if (gnt_valid_s) begin
            last_grant_r <= gnt_port_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    assign gnt_valid = gnt_valid_s;
    assign gnt_port  = gnt_port_s;

endmodule

// File: rtl/ram_large_arbiter.sv
// Arbiter/sequencer sharing a single-port synchronous RAM between IF (read-only)
// and LS (read/write); owns the RAM control pins and the tri-state data bus.
module ram_large_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = MEM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_ack,
    output logic                  ls_rvalid,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);

    memctl_state_t         state_r;
    memctl_state_t         state_nxt_s;
    logic                  gnt_valid_s;
    mem_port_t             gnt_port_s;
    logic                  sel_we_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;

    mem_port_t             lat_port_r;
    logic                  lat_we_r;
    logic [DATA_WIDTH-1:0] lat_wdata_r;
    logic [ADDR_WIDTH-1:0] ram_addr_r;
    logic                  ram_cs_r;
    logic                  ram_we_r;
    logic                  ram_oe_r;
    logic                  cs_nxt_s;
    logic                  we_nxt_s;
    logic                  oe_nxt_s;
    logic [DATA_WIDTH-1:0] if_rdata_r;
    logic [DATA_WIDTH-1:0] ls_rdata_r;
    logic                  if_rvalid_r;
    logic                  ls_rvalid_r;

    mem_rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (state_r == IDLE),
        .if_req    (if_req),
        .ls_req    (ls_req),
        .gnt_valid (gnt_valid_s),
        .gnt_port  (gnt_port_s)
    );

    // Request fields of the granted port; IF can never write.
    always_comb begin
        sel_we_s   = 1'b0;
        sel_addr_s = if_addr;
        if (gnt_port_s == PORT_LS) begin
            sel_we_s   = ls_we;
            sel_addr_s = ls_addr;
        end else begin
            sel_we_s   = 1'b0;
            sel_addr_s = if_addr;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (gnt_valid_s) begin
                    state_nxt_s = ACCESS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                if (lat_we_r) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RDATA;
                end
            end
            RDATA:   state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: RAM strobes for the cycle after this one, registered below.
    always_comb begin
        cs_nxt_s = 1'b0;
        we_nxt_s = 1'b0;
        oe_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (gnt_valid_s) begin
                    cs_nxt_s = 1'b1;
                    we_nxt_s = sel_we_s;
                    oe_nxt_s = ~sel_we_s;
                end else begin
                    cs_nxt_s = 1'b0;
                    we_nxt_s = 1'b0;
                    oe_nxt_s = 1'b0;
                end
            end
            ACCESS: begin
                // A read keeps cs/oe up through RDATA while the RAM drives its word.
                if (!lat_we_r) begin
                    cs_nxt_s = 1'b1;
                    oe_nxt_s = 1'b1;
                end else begin
                    cs_nxt_s = 1'b0;
                    oe_nxt_s = 1'b0;
                end
            end
            RDATA: begin
                cs_nxt_s = 1'b0;
                we_nxt_s = 1'b0;
                oe_nxt_s = 1'b0;
            end
            default: begin
                cs_nxt_s = 1'b0;
                we_nxt_s = 1'b0;
                oe_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered RAM strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_cs_r <= 1'b0;
            ram_we_r <= 1'b0;
            ram_oe_r <= 1'b0;
        end else begin
            ram_cs_r <= cs_nxt_s;
            ram_we_r <= we_nxt_s;
            ram_oe_r <= oe_nxt_s;
        end
    end

    // Capture the granted request; address is held until the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_port_r  <= PORT_IF;
            lat_we_r    <= 1'b0;
            lat_wdata_r <= {DATA_WIDTH{1'b0}};
            ram_addr_r  <= {ADDR_WIDTH{1'b0}};
        end else if (gnt_valid_s) begin
            lat_port_r  <= gnt_port_s;
            lat_we_r    <= sel_we_s;
            lat_wdata_r <= ls_wdata;
            ram_addr_r  <= sel_addr_s;
        end else begin
            lat_port_r  <= lat_port_r;
            lat_we_r    <= lat_we_r;
            lat_wdata_r <= lat_wdata_r;
            ram_addr_r  <= ram_addr_r;
        end
    end

    // Read return: only the owning port's data/valid change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata_r  <= {DATA_WIDTH{1'b0}};
            ls_rdata_r  <= {DATA_WIDTH{1'b0}};
            if_rvalid_r <= 1'b0;
            ls_rvalid_r <= 1'b0;
        end else if (state_r == RDATA) begin
            if (lat_port_r == PORT_IF) begin
                if_rdata_r  <= ram_data;
                if_rvalid_r <= 1'b1;
                ls_rvalid_r <= 1'b0;
            end else begin
                ls_rdata_r  <= ram_data;
                ls_rvalid_r <= 1'b1;
                if_rvalid_r <= 1'b0;
            end
        end else begin
            if_rvalid_r <= 1'b0;
            ls_rvalid_r <= 1'b0;
        end
    end

    // Write data is driven only in a write ACCESS cycle, where ram_oe is low.
    assign ram_data = (state_r == ACCESS && lat_we_r) ? lat_wdata_r : {DATA_WIDTH{1'bz}};

    assign if_ack    = gnt_valid_s && (gnt_port_s == PORT_IF);
    assign ls_ack    = gnt_valid_s && (gnt_port_s == PORT_LS);
    assign if_rvalid = if_rvalid_r;
    assign ls_rvalid = ls_rvalid_r;
    assign if_rdata  = if_rdata_r;
    assign ls_rdata  = ls_rdata_r;
    assign ram_addr  = ram_addr_r;
    assign ram_cs    = ram_cs_r;
    assign ram_we    = ram_we_r;
    assign ram_oe    = ram_oe_r;

endmodule
